pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
Instruction-fetch stage directly downstream of the branch-decision AND gate, which drives `pc_src` = Branch & Zero.
- Holds the program counter and issues requests to instruction memory with a req/ack handshake.
- Presents the fetched instruction to the IF/ID boundary.
- On a taken branch or jump: redirects the PC, discards any in-flight fetch, and pulses `flush`.

Parameters:
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_src  in  1  branch taken, from the AND gate (Branch & Zero)
- branch_target  in  ADDR_W  PC-relative branch destination
- jump  in  1  unconditional jump
- jump_target  in  ADDR_W  jump destination
- stall  in  1  hazard stall; freezes the IF output and blocks new requests
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  ADDR_W  fetch address (equals pc)
- imem_ack  in  1  one-cycle acknowledge; imem_rdata valid in the same cycle
- imem_rdata  in  INSTR_W  fetched instruction
- if_valid  out  1  if_instr/if_pc hold a live instruction
- if_instr  out  INSTR_W  instruction to decode
- if_pc  out  ADDR_W  address of if_instr
- if_pc_plus4  out  ADDR_W  if_pc + 4, modulo 2^ADDR_W
- flush  out  1  one-cycle pulse on redirect
- redirect_count  out  16  taken-redirect count (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - pc=RESET_PC, state=BOOT
  - imem_req=0, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, flush=0, hold buffer empty, redirect_count=0
- Reset asserted mid-request abandons the request; a late ack after reset is ignored in BOOT.
- Redirect condition: `redir = jump | pc_src`.
  - Target is jump_target if jump is set, else branch_target (jump has priority).
  - Redirect overrides stall.
- States:
  - BOOT: imem_req=0 for exactly one cycle after rst_n deasserts, then FETCH.
  - FETCH:
    - imem_req = !stall & !redir.
    - Ack with no stall and no redir: register if_instr=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, if_valid=1. Set pc=pc+4 and stay in FETCH, so back-to-back fetch is possible with one instruction per cycle when ack returns each cycle.
    - Ack with stall: capture imem_rdata/pc into the hold buffer, pc=pc+4, go to HOLD. if_* stays frozen.
    - No ack: hold imem_req/imem_addr stable. Stall arriving while req is pending does not drop req.
    - redir: pc=target, flush=1 for one cycle, if_valid=0 next cycle. Go to DRAIN if a request is pending without ack this cycle; otherwise stay in FETCH.
  - HOLD:
    - imem_req=0.
    - When stall drops: move the buffer to if_*, if_valid=1, go to FETCH.
    - redir: discard the buffer, pc=target, flush, go to FETCH.
  - DRAIN:
    - imem_req held high with the old address until imem_ack; that data is discarded.
    - Then go to FETCH with the new pc.
    - A further redir in DRAIN updates pc and pulses flush again, and stays in DRAIN.
- While stall=1 and no redir, all if_* outputs are held.
- PC arithmetic wraps modulo 2^ADDR_W: 0xFFFFFFFC + 4 = 0x00000000. Low address bits are not checked.
- flush is never high for two consecutive cycles unless redir is asserted in both cycles.
- Redirect latency: target appears on imem_addr in the cycle after redir. The first redirected instruction reaches if_valid no earlier than 2 cycles after redir.

Optional Feature:
- Macro: PC_FETCH_PERF_EN.
- Defined:
  - redirect_count increments on every cycle that pulses flush.
  - It saturates at 0xFFFF and is cleared only by reset.
- Undefined:
  - redirect_count is tied to 0.
  - The counter logic is not synthesised.
  - Port list is unchanged.

Test Plan:
1. Reset release with RESET_PC=0x100, ack each cycle → imem_req low in BOOT; then addrs 0x100, 0x104, 0x108; if_pc follows with 1-cycle lag and if_valid=1.
2. stall=1 while req at 0x200 pending, ack arrives → data held (HOLD), imem_req=0, if_* frozen; stall=0 → if_pc=0x200, next fetch 0x204.
3. pc_src=1, branch_target=0x400 while req at 0x108 pending (ack 2 cycles later) → flush one cycle, if_valid=0, 0x108 data discarded, next request 0x400.
4. jump=1 (0x800) and pc_src=1 (0x400) in the same cycle with stall=1 → imem_addr=0x800 next, flush=1, stall ignored.
5. pc=0xFFFFFFFC fetched → next imem_addr=0x0, if_pc_plus4=0x0.
6. With PC_FETCH_PERF_EN: 3 redirects → redirect_count=3; without the macro → 0; rst_n pulse mid-DRAIN → all outputs at reset values, BOOT.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: PC register, imem req/ack handshake, IF/ID output register, redirect/flush.
// Optional redirect counter is enabled with `define PC_FETCH_PERF_EN.
module pc_fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_src,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  jump_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               flush,
  output logic [15:0]        redirect_count
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  drain_addr;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  hold_pc;
  logic [INSTR_W-1:0] hold_instr;
  logic               pending;
  logic               redir;
  logic               acc;

  assign redir    = jump | pc_src;
  assign target   = jump ? jump_target : branch_target;
  assign pc_plus4 = pc + ADDR_W'(4);
  assign acc      = imem_req & imem_ack;

  // A request left un-acked stays asserted whatever stall/redir do, so the handshake is never broken.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    case (state)
      FETCH:   imem_req = pending | (!stall & !redir);
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      default: ;
    endcase
  end

  // NOTE: all state is updated with non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      drain_addr  <= '0;
      hold_pc     <= '0;
      hold_instr  <= '0;
      pending     <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
      flush       <= 1'b0;
    end else begin
      flush   <= redir;
      pending <= 1'b0;
      case (state)
        BOOT: begin
          if (redir) pc <= target;
          state <= FETCH;
        end
        FETCH: begin
          if (redir) begin
            pc       <= target;
            if_valid <= 1'b0;
            if (imem_req && !imem_ack) begin
              drain_addr <= pc;
              state      <= DRAIN;
            end
          end else if (acc && stall) begin
            hold_instr <= imem_rdata;
            hold_pc    <= pc;
            pc         <= pc_plus4;
            state      <= HOLD;
          end else if (acc) begin
            if_instr    <= imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4;
            if_valid    <= 1'b1;
            pc          <= pc_plus4;
          end else begin
            pending <= imem_req;
            if (!stall) if_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redir) begin
            pc       <= target;
            if_valid <= 1'b0;
            state    <= FETCH;
          end else if (!stall) begin
            if_instr    <= hold_instr;
            if_pc       <= hold_pc;
            if_pc_plus4 <= hold_pc + ADDR_W'(4);
            if_valid    <= 1'b1;
            state       <= FETCH;
          end
        end
        DRAIN: begin
          // The stale response is dropped; only the ack matters here.
          if (redir) pc <= target;
          if (imem_ack) state <= FETCH;
        end
        default: state <= BOOT;
      endcase
    end
  end

`ifdef PC_FETCH_PERF_EN
  // Counts alongside flush, saturating so a long run never wraps back to a small value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_count <= '0;
    end else if (redir && redirect_count != 16'hFFFF) begin
      redirect_count <= redirect_count + 16'd1;
    end
  end
`else
  assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (RESET_PC = 0x100); memory returns addr ^ 0xDEAD0000.
module tb_pc_fetch_unit;
  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        flush;
  logic [15:0] redirect_count;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef PC_FETCH_PERF_EN
  localparam logic [15:0] CNT3 = 16'd3;
  localparam logic [15:0] CNT6 = 16'd6;
`else
  localparam logic [15:0] CNT3 = 16'd0;
  localparam logic [15:0] CNT6 = 16'd0;
`endif

  pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .flush(flush), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ K;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_src = 1'b0; jump = 1'b0; stall = 1'b0; imem_ack = 1'b1;
    branch_target = '0; jump_target = '0;
    repeat (3) tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL rst_addr: got %h want 00000100", imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid: got %b want 0", if_valid); end
    n_checks++; if (if_pc !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc: got %h want 0", if_pc); end
    n_checks++; if (if_instr !== 32'h0) begin n_fail++; $display("FAIL rst_if_instr: got %h want 0", if_instr); end
    n_checks++; if (if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL rst_if_pc_plus4: got %h want 0", if_pc_plus4); end
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b want 0", flush); end
    n_checks++; if (redirect_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", redirect_count); end
  endtask

  task automatic test_boot_fetch();
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch0_req: got %b want 1", imem_req); end
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL fetch0_addr: got %h want 00000100", imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL fetch0_valid: got %b want 0", if_valid); end
    tick();
    n_checks++; if (if_valid !== 1'b1) begin n_fail++; $display("FAIL fetch1_valid: got %b want 1", if_valid); end
    n_checks++; if (if_pc !== 32'h100) begin n_fail++; $display("FAIL fetch1_if_pc: got %h want 00000100", if_pc); end
    n_checks++; if (if_instr !== (32'h100 ^ K)) begin n_fail++; $display("FAIL fetch1_instr: got %h want %h", if_instr, 32'h100 ^ K); end
    n_checks++; if (if_pc_plus4 !== 32'h104) begin n_fail++; $display("FAIL fetch1_plus4: got %h want 00000104", if_pc_plus4); end
    n_checks++; if (imem_addr !== 32'h104) begin n_fail++; $display("FAIL fetch1_addr: got %h want 00000104", imem_addr); end
    tick();
    n_checks++; if (if_pc !== 32'h104) begin n_fail++; $display("FAIL fetch2_if_pc: got %h want 00000104", if_pc); end
    n_checks++; if (imem_addr !== 32'h108) begin n_fail++; $display("FAIL fetch2_addr: got %h want 00000108", imem_addr); end
  endtask

  task automatic test_branch_discard();
    imem_ack = 1'b0;
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin n_fail++; $display("FAIL br_pending: got req=%b addr=%h want req=1 addr=00000108", imem_req, imem_addr); end
    pc_src = 1'b1; branch_target = 32'h400;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL br_req_kept: got %b want 1", imem_req); end
    tick();
    pc_src = 1'b0;
    n_checks++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush: got %b want 1", flush); end
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL br_valid: got %b want 0", if_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin n_fail++; $display("FAIL br_drain: got req=%b addr=%h want req=1 addr=00000108", imem_req, imem_addr); end
    tick();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush_once: got %b want 0", flush); end
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h400) begin n_fail++; $display("FAIL br_target: got req=%b addr=%h want req=1 addr=00000400", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h104) begin n_fail++; $display("FAIL br_discard: got valid=%b pc=%h want valid=0 pc=00000104", if_valid, if_pc); end
    imem_ack = 1'b1;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h400) begin n_fail++; $display("FAIL br_first: got valid=%b pc=%h want valid=1 pc=00000400", if_valid, if_pc); end
  endtask

  task automatic test_hold();
    imem_ack = 1'b0; jump = 1'b1; jump_target = 32'h200;
    tick();
    jump = 1'b0;
    n_checks++; if (flush !== 1'b1 || imem_addr !== 32'h200) begin n_fail++; $display("FAIL hold_jump: got flush=%b addr=%h want flush=1 addr=00000200", flush, imem_addr); end
    tick();
    stall = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL hold_req_kept: got %b want 1", imem_req); end
    tick();
    imem_ack = 1'b1;
    tick();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL hold_req: got %b want 0", imem_req); end
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h400) begin n_fail++; $display("FAIL hold_frozen: got valid=%b pc=%h want valid=0 pc=00000400", if_valid, if_pc); end
    tick();
    n_checks++; if (imem_req !== 1'b0 || if_pc !== 32'h400) begin n_fail++; $display("FAIL hold_frozen2: got req=%b pc=%h want req=0 pc=00000400", imem_req, if_pc); end
    stall = 1'b0;
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200) begin n_fail++; $display("FAIL hold_release: got valid=%b pc=%h want valid=1 pc=00000200", if_valid, if_pc); end
    n_checks++; if (if_instr !== (32'h200 ^ K)) begin n_fail++; $display("FAIL hold_instr: got %h want %h", if_instr, 32'h200 ^ K); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin n_fail++; $display("FAIL hold_next: got req=%b addr=%h want req=1 addr=00000204", imem_req, imem_addr); end
    tick();
    n_checks++; if (if_pc !== 32'h204) begin n_fail++; $display("FAIL hold_after: got %h want 00000204", if_pc); end
  endtask

  task automatic test_jump_priority();
    stall = 1'b1; jump = 1'b1; jump_target = 32'h800; pc_src = 1'b1; branch_target = 32'h400;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL jp_req: got %b want 0", imem_req); end
    tick();
    jump = 1'b0; pc_src = 1'b0;
    n_checks++; if (imem_addr !== 32'h800) begin n_fail++; $display("FAIL jp_addr: got %h want 00000800", imem_addr); end
    n_checks++; if (flush !== 1'b1 || if_valid !== 1'b0) begin n_fail++; $display("FAIL jp_flush: got flush=%b valid=%b want flush=1 valid=0", flush, if_valid); end
    stall = 1'b0;
    tick();
    n_checks++; if (flush !== 1'b0) begin n_fail++; $display("FAIL jp_flush_once: got %b want 0", flush); end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h800) begin n_fail++; $display("FAIL jp_first: got valid=%b pc=%h want valid=1 pc=00000800", if_valid, if_pc); end
    n_checks++; if (redirect_count !== CNT3) begin n_fail++; $display("FAIL count3: got %0d want %0d", redirect_count, CNT3); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFC; imem_ack = 1'b0;
    tick();
    jump = 1'b0; imem_ack = 1'b1;
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); end
    tick();
    n_checks++; if (if_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_if_pc: got %h want fffffffc", if_pc); end
    n_checks++; if (if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_plus4: got %h want 0", if_pc_plus4); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", imem_addr); end
  endtask

  task automatic test_drain_reset();
    imem_ack = 1'b0;
    tick();
    pc_src = 1'b1; branch_target = 32'h40;
    tick();
    branch_target = 32'h80;
    n_checks++; if (flush !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL dr_enter: got flush=%b req=%b addr=%h want 1 1 0", flush, imem_req, imem_addr); end
    tick();
    pc_src = 1'b0;
    n_checks++; if (flush !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL dr_again: got flush=%b addr=%h want flush=1 addr=0", flush, imem_addr); end
    n_checks++; if (redirect_count !== CNT6) begin n_fail++; $display("FAIL count6: got %0d want %0d", redirect_count, CNT6); end
    rst_n = 1'b0; imem_ack = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin n_fail++; $display("FAIL dr_rst_req: got req=%b addr=%h want req=0 addr=00000100", imem_req, imem_addr); end
    n_checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || if_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL dr_rst_if: got valid=%b pc=%h instr=%h p4=%h want all 0", if_valid, if_pc, if_instr, if_pc_plus4); end
    n_checks++; if (flush !== 1'b0 || redirect_count !== 16'd0) begin n_fail++; $display("FAIL dr_rst_flush: got flush=%b count=%0d want 0 0", flush, redirect_count); end
    tick();
    rst_n = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL dr_boot_req: got %b want 0", imem_req); end
    tick();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || if_valid !== 1'b0) begin n_fail++; $display("FAIL dr_refetch: got req=%b addr=%h valid=%b want 1 00000100 0", imem_req, imem_addr, if_valid); end
    tick();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_fail++; $display("FAIL dr_first: got valid=%b pc=%h want valid=1 pc=00000100", if_valid, if_pc); end
  endtask

  initial begin
    test_reset();
    test_boot_fetch();
    test_branch_discard();
    test_hold();
    test_jump_priority();
    test_wrap();
    test_drain_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
